// File: rtl/uart_core_param.sv
// uart_core_param: full-duplex UART core with a shared 16x baud-tick generator,
// a TX engine and an RX engine (false-start rejection, frame/parity error flags).
// Optional parity bit: define UART_PARITY_EN to enable it.
//
//  state   | meaning
//  --------+---------------------------------------------------------------
//  S_IDLE  | line idle; TX waits for tx_start, RX waits for a low level
//  S_START | start bit; RX re-checks the line at mid-bit to reject glitches
//  S_DATA  | DBIT data bits, LSB first, 16 ticks each
//  S_PAR   | parity bit (parity build only)
//  S_STOP  | stop period of SB_TICK ticks; RX samples and reports the frame
module uart_core_param #(
  parameter int DBIT    = 8,
  parameter int SB_TICK = 16,
  parameter int DVSR_W  = 11
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic [DVSR_W-1:0] dvsr_i,
  input  logic [DBIT-1:0]   tx_data_i,
  input  logic              tx_start_i,
  output logic              tx_o,
  output logic              tx_busy_o,
  output logic              tx_done_tick_o,
  input  logic              rx_i,
  output logic [DBIT-1:0]   rx_data_o,
  output logic              rx_done_tick_o,
  output logic              frame_err_o,
  input  logic              par_odd_i,
  output logic              parity_err_o
);

`ifdef UART_PARITY_EN
  localparam bit PAR_EN = 1'b1;
`else
  localparam bit PAR_EN = 1'b0;
`endif

  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PAR, S_STOP} state_e;

  localparam logic [5:0] TICK_MID  = 6'd7;
  localparam logic [5:0] TICK_LAST = 6'd15;
  localparam logic [5:0] STOP_LAST = 6'(SB_TICK - 1);
  localparam logic [3:0] BIT_LAST  = 4'(DBIT - 1);

  logic [DVSR_W-1:0] baud_q;
  logic              s_tick;
  logic [1:0]        rx_sync_q;
  logic              rx_sync;

  assign s_tick  = (baud_q >= dvsr_i);
  assign rx_sync = rx_sync_q[1];

  // Free-running baud counter and two-flop synchroniser for the async rx pin
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      baud_q    <= '0;
      rx_sync_q <= 2'b11;
    end else begin
      baud_q    <= s_tick ? '0 : baud_q + 1'b1;
      rx_sync_q <= {rx_sync_q[0], rx_i};
    end
  end

  // ---------------------------------------------------------------- RX
  state_e            rx_state_q, rx_state_d;
  logic [5:0]        rx_tick_q, rx_tick_d;
  logic [3:0]        rx_bit_q, rx_bit_d;
  logic [DBIT-1:0]   rx_b_q, rx_b_d;
  logic              rx_p_q, rx_p_d;
  logic [DBIT-1:0]   rx_data_q, rx_data_d;
  logic              rx_done_q, rx_done_d;
  logic              frame_err_q, frame_err_d;
  logic              parity_err_q, parity_err_d;

  // RX state and datapath registers
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      rx_state_q   <= S_IDLE;
      rx_tick_q    <= '0;
      rx_bit_q     <= '0;
      rx_b_q       <= '0;
      rx_p_q       <= 1'b0;
      rx_data_q    <= '0;
      rx_done_q    <= 1'b0;
      frame_err_q  <= 1'b0;
      parity_err_q <= 1'b0;
    end else begin
      rx_state_q   <= rx_state_d;
      rx_tick_q    <= rx_tick_d;
      rx_bit_q     <= rx_bit_d;
      rx_b_q       <= rx_b_d;
      rx_p_q       <= rx_p_d;
      rx_data_q    <= rx_data_d;
      rx_done_q    <= rx_done_d;
      frame_err_q  <= frame_err_d;
      parity_err_q <= parity_err_d;
    end
  end

  // RX next state: tick counting, mid-bit sampling and shift-in
  always_comb begin
    rx_state_d = rx_state_q;
    rx_tick_d  = rx_tick_q;
    rx_bit_d   = rx_bit_q;
    rx_b_d     = rx_b_q;
    rx_p_d     = rx_p_q;
    case (rx_state_q)
      S_IDLE: if (!rx_sync) begin
        rx_state_d = S_START;
        rx_tick_d  = '0;
      end
      S_START: if (s_tick) begin
        if (rx_tick_q == TICK_MID) begin
          rx_tick_d  = '0;
          rx_bit_d   = '0;
          rx_state_d = rx_sync ? S_IDLE : S_DATA;
        end else rx_tick_d = rx_tick_q + 6'd1;
      end
      S_DATA: if (s_tick) begin
        if (rx_tick_q == TICK_LAST) begin
          rx_tick_d = '0;
          rx_b_d    = {rx_sync, rx_b_q[DBIT-1:1]};
          if (rx_bit_q == BIT_LAST) rx_state_d = PAR_EN ? S_PAR : S_STOP;
          else                      rx_bit_d   = rx_bit_q + 4'd1;
        end else rx_tick_d = rx_tick_q + 6'd1;
      end
      S_PAR: if (s_tick) begin
        if (rx_tick_q == TICK_LAST) begin
          rx_tick_d  = '0;
          rx_p_d     = rx_sync;
          rx_state_d = S_STOP;
        end else rx_tick_d = rx_tick_q + 6'd1;
      end
      S_STOP: if (s_tick) begin
        if (rx_tick_q == STOP_LAST) rx_state_d = S_IDLE;
        else                        rx_tick_d  = rx_tick_q + 6'd1;
      end
      default: rx_state_d = S_IDLE;
    endcase
  end

  // RX outputs: word and error flags update only with the done pulse
  always_comb begin
    rx_done_d    = (rx_state_q == S_STOP) && s_tick && (rx_tick_q == STOP_LAST);
    rx_data_d    = rx_done_d ? rx_b_q : rx_data_q;
    frame_err_d  = rx_done_d ? ~rx_sync : frame_err_q;
    parity_err_d = rx_done_d ? (PAR_EN && (((^rx_b_q) ^ par_odd_i) != rx_p_q))
                             : parity_err_q;
  end

  assign rx_data_o      = rx_data_q;
  assign rx_done_tick_o = rx_done_q;
  assign frame_err_o    = frame_err_q;
  assign parity_err_o   = parity_err_q;

  // ---------------------------------------------------------------- TX
  state_e          tx_state_q, tx_state_d;
  logic [5:0]      tx_tick_q, tx_tick_d;
  logic [3:0]      tx_bit_q, tx_bit_d;
  logic [DBIT-1:0] tx_b_q, tx_b_d;
  logic            tx_p_q, tx_p_d;
  logic            tx_q, tx_d;
  logic            tx_done_q, tx_done_d;
  logic            tx_accept;

  // The done cycle itself refuses a new request, so held tx_start restarts one cycle later
  assign tx_accept = (tx_state_q == S_IDLE) && tx_start_i && !tx_done_q;

  // TX state and datapath registers
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      tx_state_q <= S_IDLE;
      tx_tick_q  <= '0;
      tx_bit_q   <= '0;
      tx_b_q     <= '0;
      tx_p_q     <= 1'b0;
      tx_q       <= 1'b1;
      tx_done_q  <= 1'b0;
    end else begin
      tx_state_q <= tx_state_d;
      tx_tick_q  <= tx_tick_d;
      tx_bit_q   <= tx_bit_d;
      tx_b_q     <= tx_b_d;
      tx_p_q     <= tx_p_d;
      tx_q       <= tx_d;
      tx_done_q  <= tx_done_d;
    end
  end

  // TX next state: latch on accept, 16 ticks per bit, SB_TICK for stop
  always_comb begin
    tx_state_d = tx_state_q;
    tx_tick_d  = tx_tick_q;
    tx_bit_d   = tx_bit_q;
    tx_b_d     = tx_b_q;
    tx_p_d     = tx_p_q;
    case (tx_state_q)
      S_IDLE: if (tx_accept) begin
        tx_state_d = S_START;
        tx_tick_d  = '0;
        tx_b_d     = tx_data_i;
        tx_p_d     = (^tx_data_i) ^ par_odd_i;
      end
      S_START: if (s_tick) begin
        if (tx_tick_q == TICK_LAST) begin
          tx_tick_d  = '0;
          tx_bit_d   = '0;
          tx_state_d = S_DATA;
        end else tx_tick_d = tx_tick_q + 6'd1;
      end
      S_DATA: if (s_tick) begin
        if (tx_tick_q == TICK_LAST) begin
          tx_tick_d = '0;
          tx_b_d    = tx_b_q >> 1;
          if (tx_bit_q == BIT_LAST) tx_state_d = PAR_EN ? S_PAR : S_STOP;
          else                      tx_bit_d   = tx_bit_q + 4'd1;
        end else tx_tick_d = tx_tick_q + 6'd1;
      end
      S_PAR: if (s_tick) begin
        if (tx_tick_q == TICK_LAST) begin
          tx_tick_d  = '0;
          tx_state_d = S_STOP;
        end else tx_tick_d = tx_tick_q + 6'd1;
      end
      S_STOP: if (s_tick) begin
        if (tx_tick_q == STOP_LAST) tx_state_d = S_IDLE;
        else                        tx_tick_d  = tx_tick_q + 6'd1;
      end
      default: tx_state_d = S_IDLE;
    endcase
  end

  // TX outputs: line level follows the upcoming state so tx is registered
  always_comb begin
    case (tx_state_d)
      S_START: tx_d = 1'b0;
      S_DATA:  tx_d = tx_b_d[0];
      S_PAR:   tx_d = tx_p_q;
      default: tx_d = 1'b1;
    endcase
    tx_done_d = (tx_state_q == S_STOP) && s_tick && (tx_tick_q == STOP_LAST);
  end

  assign tx_o           = tx_q;
  assign tx_done_tick_o = tx_done_q;
  assign tx_busy_o      = (tx_state_q != S_IDLE) || tx_done_q;

endmodule

// File: tb/tb_uart_core_param.sv
// Self-checking bench for uart_core_param: random loopback and injected frames
// against a queue-based frame model and an independent serial-line decoder.
module tb_uart_core_param;
  localparam int DBIT    = 8;
  localparam int SB_TICK = 16;
  localparam int DVSR_W  = 11;
  localparam int DVSR    = 14;
`ifdef UART_PARITY_EN
  localparam int PB = 1;
`else
  localparam int PB = 0;
`endif
  localparam int CLK_P   = 10;
  localparam int BIT_T   = 16 * (DVSR + 1) * CLK_P;
  localparam int T_TICKS = 16 * (DBIT + 1 + PB) + SB_TICK;
  localparam int T_LO    = (T_TICKS - 1) * (DVSR + 1) - 1;
  localparam int T_HI    = T_TICKS * (DVSR + 1) + 3;

  logic              clk, rst_n;
  logic [DVSR_W-1:0] dvsr;
  logic [DBIT-1:0]   tx_data;
  logic              tx_start, tx, tx_busy, tx_done;
  logic              rx, rx_done, frame_err, par_odd, parity_err;
  logic [DBIT-1:0]   rx_data;
  logic              loop_en, rx_drv, tx_mon_en;

  assign rx = loop_en ? tx : rx_drv;

  uart_core_param #(.DBIT(DBIT), .SB_TICK(SB_TICK), .DVSR_W(DVSR_W)) dut (
    .clk_i(clk), .rst_ni(rst_n), .dvsr_i(dvsr), .tx_data_i(tx_data),
    .tx_start_i(tx_start), .tx_o(tx), .tx_busy_o(tx_busy),
    .tx_done_tick_o(tx_done), .rx_i(rx), .rx_data_o(rx_data),
    .rx_done_tick_o(rx_done), .frame_err_o(frame_err), .par_odd_i(par_odd),
    .parity_err_o(parity_err));

  initial clk = 1'b0;
  always #(CLK_P / 2) clk = ~clk;

  int n_cmp = 0, n_err = 0;
  int rx_done_cnt = 0, tx_done_cnt = 0, n_rx_pushed = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic par_of(input logic [DBIT-1:0] d, input logic odd);
    return (^d) ^ odd;
  endfunction

  typedef struct packed {logic [DBIT-1:0] d; logic fe; logic pe;} rexp_t;
  rexp_t           rx_exp_q[$];
  logic [DBIT-1:0] tx_exp_q[$];
  rexp_t           mon_e;

  task automatic push_rx(input logic [DBIT-1:0] d, input logic fe, input logic pe);
    rexp_t e;
    e.d = d; e.fe = fe; e.pe = pe;
    rx_exp_q.push_back(e);
    n_rx_pushed++;
  endtask

  // RX scoreboard: every done pulse must match the oldest expected frame
  always @(negedge clk) begin
    if (rx_done === 1'b1) begin
      rx_done_cnt++;
      if (rx_exp_q.size() == 0) chk("rx_unexpected_done", 1, 0);
      else begin
        mon_e = rx_exp_q.pop_front();
        chk("rx_data", rx_data, mon_e.d);
        chk("frame_err", frame_err, mon_e.fe);
        chk("parity_err", parity_err, mon_e.pe);
      end
    end
    if (tx_done === 1'b1) tx_done_cnt++;
  end

  // Serial-line decoder on tx: sample each bit near its middle from the start edge
  logic [15:0]     fr;
  logic [DBIT-1:0] dec_d;
  initial begin
    forever begin
      @(negedge tx);
      #(BIT_T / 2 - 70);
      fr[0] = tx;
      for (int k = 1; k < DBIT + PB + 2; k++) begin
        #(BIT_T);
        fr[k] = tx;
      end
      if (tx_mon_en) begin
        if (tx_exp_q.size() == 0) chk("tx_unexpected_frame", 1, 0);
        else begin
          dec_d = tx_exp_q.pop_front();
          chk("tx_start_bit", fr[0], 0);
          chk("tx_data_bits", fr[DBIT:1], dec_d);
`ifdef UART_PARITY_EN
          chk("tx_parity_bit", fr[DBIT+1], par_of(dec_d, par_odd));
`endif
          chk("tx_stop_bit", fr[DBIT+1+PB], 1);
        end
      end
    end
  end

  // Transmit one word; called and returns at a negedge
  task automatic send_tx(input logic [DBIT-1:0] d);
    int cyc;
    tx_data = d;
    tx_exp_q.push_back(d);
    if (loop_en) push_rx(d, 1'b0, 1'b0);
    tx_start = 1'b1;
    cyc = 0;
    while (!tx_busy && cyc < 40) begin @(negedge clk); cyc++; end
    chk("tx_accept", tx_busy, 1);
    tx_start = 1'b0;
    while (!tx_done && cyc < 3000) begin @(negedge clk); cyc++; end
    chk("tx_done_seen", tx_done, 1);
    chk("tx_frame_time", (cyc >= T_LO && cyc <= T_HI), 1);
    @(negedge clk);
  endtask

  // Drive one frame onto rx; a low stop bit is released shortly after mid-bit
  task automatic send_rx(input logic [DBIT-1:0] d, input logic stopb, input logic flip);
    push_rx(d, ~stopb, (PB != 0) && flip);
    rx_drv = 1'b0; #(BIT_T);
    for (int i = 0; i < DBIT; i++) begin rx_drv = d[i]; #(BIT_T); end
`ifdef UART_PARITY_EN
    rx_drv = par_of(d, par_odd) ^ flip; #(BIT_T);
`endif
    rx_drv = stopb;
    if (stopb) #(BIT_T);
    else begin #(BIT_T / 2 + 450); rx_drv = 1'b1; #(BIT_T / 2 - 450); end
    rx_drv = 1'b1; #(BIT_T);
    @(negedge clk);
  endtask

  int c_rx, c_tx, lowc, cyc;

  initial begin
    rst_n = 1'b0; dvsr = DVSR[DVSR_W-1:0]; tx_data = '0; tx_start = 1'b0;
    par_odd = 1'b0; loop_en = 1'b1; rx_drv = 1'b1; tx_mon_en = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_tx", tx, 1);
    chk("rst_tx_busy", tx_busy, 0);
    chk("rst_tx_done", tx_done, 0);
    chk("rst_rx_done", rx_done, 0);
    chk("rst_rx_data", rx_data, 0);
    chk("rst_frame_err", frame_err, 0);
    chk("rst_parity_err", parity_err, 0);
    rst_n = 1'b1; tx_mon_en = 1'b1;
    repeat (5) @(negedge clk);

    // loopback: fixed word then random words with random parity sense
    send_tx(8'hA5);
    repeat (5) begin
      par_odd = 1'($urandom_range(0, 1));
      send_tx(DBIT'($urandom));
    end
    par_odd = 1'b0;

    // injected frames: bad stop bit, false start, random words and stop bits
    loop_en = 1'b0;
    send_rx(8'h3C, 1'b0, 1'b0);
    rx_drv = 1'b0; #(750); rx_drv = 1'b1;
    c_rx = rx_done_cnt;
    #(3 * BIT_T);
    @(negedge clk);
    chk("false_start_no_done", rx_done_cnt, c_rx);
    send_rx(8'h55, 1'b1, 1'b0);
    repeat (4) send_rx(DBIT'($urandom), 1'($urandom_range(0, 1)),
                       (PB != 0) && ($urandom_range(0, 1) == 1));

`ifdef UART_PARITY_EN
    loop_en = 1'b1;
    send_tx(8'h07);
    loop_en = 1'b0;
    send_rx(8'h07, 1'b1, 1'b1);
`endif

    // held tx_start: two frames back to back, busy low for one cycle only
    loop_en = 1'b1;
    tx_exp_q.push_back(8'h81); push_rx(8'h81, 1'b0, 1'b0);
    tx_exp_q.push_back(8'h18); push_rx(8'h18, 1'b0, 1'b0);
    tx_data = 8'h81; tx_start = 1'b1;
    cyc = 0;
    while (!tx_busy && cyc < 40) begin @(negedge clk); cyc++; end
    chk("b2b_accept1", tx_busy, 1);
    tx_data = 8'h18;
    cyc = 0;
    while (!tx_done && cyc < 3000) begin @(negedge clk); cyc++; end
    chk("b2b_done1", tx_done, 1);
    lowc = 0;
    repeat (4) begin @(negedge clk); if (!tx_busy) lowc++; end
    chk("b2b_busy_low_cycles", lowc, 1);
    tx_start = 1'b0;
    cyc = 0;
    while (!tx_done && cyc < 3000) begin @(negedge clk); cyc++; end
    chk("b2b_done2", tx_done, 1);
    @(negedge clk);

    // reset in mid-DATA on both paths
    tx_mon_en = 1'b0;
    tx_data = DBIT'($urandom); tx_start = 1'b1;
    cyc = 0;
    while (!tx_busy && cyc < 40) begin @(negedge clk); cyc++; end
    tx_start = 1'b0;
    #(4 * BIT_T);
    @(negedge clk);
    c_rx = rx_done_cnt; c_tx = tx_done_cnt;
    rst_n = 1'b0;
    @(posedge clk); #1;
    chk("midrst_tx", tx, 1);
    chk("midrst_tx_busy", tx_busy, 0);
    repeat (20) @(negedge clk);
    chk("midrst_rx_data", rx_data, 0);
    rst_n = 1'b1;
    #(12 * BIT_T);
    @(negedge clk);
    chk("midrst_no_rx_done", rx_done_cnt, c_rx);
    chk("midrst_no_tx_done", tx_done_cnt, c_tx);
    tx_mon_en = 1'b1;
    send_tx(8'hF0);

    #(2 * BIT_T);
    @(negedge clk);
    chk("rx_frames_pending", rx_exp_q.size(), 0);
    chk("tx_frames_pending", tx_exp_q.size(), 0);
    chk("rx_done_total", rx_done_cnt, n_rx_pushed);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
